// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NREQ byte producers using round-robin
// arbitration. The winner's byte is captured in IDLE, launched with a
// single-cycle tx_start once the transmitter is not busy, and the grant is
// held until tx_done. A guard gap of GUARD cycles follows each frame before
// the next arbitration.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a frame that sees no tx_done within TIMEOUT cycles of
//   tx_start is abandoned (no frame_done) and timeout_err is set until rst.
//   When undefined, WAIT_DONE waits indefinitely and timeout_err is tied 0.
//
// Ports:
//   clk2        in   clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   req_valid   in   [NREQ]     per-requester byte pending, held until ready
//   req_data    in   [NREQ*DW]  requester i byte at [i*DW +: DW]
//   req_ready   out  [NREQ]     one-cycle capture pulse to the winner
//   tx_start    out             one-cycle launch pulse to the transmitter
//   tx_data     out  [DW]       byte being transmitted, stable until tx_done
//   tx_busy     in              transmitter is shifting a frame
//   tx_done     in              one-cycle pulse at end of stop bit
//   grant_id    out  [log2 NREQ] current/last granted requester
//   frame_done  out  [NREQ]     one-cycle completion pulse to the owner
//   busy        out             high in any state other than IDLE
//   timeout_err out             sticky frame timeout flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk2,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [NREQ-1:0]         frame_done,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;
  localparam int GW  = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  state_e            state_q,      state_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IDW-1:0]    grant_id_q,   grant_id_d;
  logic [DW-1:0]     tx_data_q,    tx_data_d;
  logic [GW-1:0]     gap_cnt_q,    gap_cnt_d;
  logic [NREQ-1:0]   req_ready_q,  req_ready_d;
  logic              tx_start_q,   tx_start_d;
  logic [NREQ-1:0]   frame_done_q, frame_done_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0]    to_cnt_q,      to_cnt_d;
  logic              timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick: scan upward from last_grant+1 with wrap. scan_sum
  // carries one extra bit so last_grant+k never overflows before the wrap.
  logic              found;
  logic [IDW-1:0]    winner;
  logic [SW-1:0]     scan_sum;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_sum = {1'b0, last_grant_q} + SW'(k);
      if (scan_sum >= SW'(NREQ)) begin
        scan_sum = scan_sum - SW'(NREQ);
      end
      if (!found && req_valid[scan_sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan_sum[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    gap_cnt_d    = gap_cnt_q;
    req_ready_d  = '0;
    tx_start_d   = 1'b0;
    frame_done_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d          = winner;
          last_grant_d        = winner;
          tx_data_d           = req_data[int'(winner)*DW +: DW];
          req_ready_d[winner] = 1'b1;
          state_d             = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      WAIT_DONE: begin
        // A tx_done coinciding with our own tx_start belongs to an earlier
        // frame and must not complete this one.
        if (tx_done && !tx_start_q) begin
          frame_done_d[grant_id_q] = 1'b1;
          gap_cnt_d                = '0;
          if (GUARD == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          gap_cnt_d     = '0;
          if (GUARD == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
`endif
      end
      GAP: begin
        if (gap_cnt_q == GW'(GUARD - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register boundary.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NREQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      gap_cnt_q     <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      frame_done_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      gap_cnt_q     <= gap_cnt_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      frame_done_q  <= frame_done_d;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Scenario tasks are called in
// sequence; each drives stimulus and compares DUT outputs against values
// derived from the arbitration rules (round-robin pick, fixed latencies,
// guard gap). A small transmitter model and random requesters are advanced
// once per clock by step().
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 16;
  localparam int IDW     = $clog2(NREQ);

  logic                 clk2 = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DW-1:0]        tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [IDW-1:0]       grant_id;
  logic [NREQ-1:0]      frame_done;
  logic                 busy;
  logic                 timeout_err;

  int checks = 0;
  int errors = 0;

  // Random requester and transmitter model controls.
  bit              req_auto = 1'b0;
  logic [NREQ-1:0] req_mask = '0;
  int              req_pct  = 0;
  int              drop_pct = 0;
  bit              bfm_auto = 1'b0;
  int              bfm_lo = 1, bfm_hi = 1, bfm_cnt = 0, bfm_cur_len = 0;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DW(DW), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk2(clk2), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk2 = ~clk2;

  // Reference arbitration rule: lowest active index above the last grant,
  // otherwise lowest active index overall.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int first_any   = -1;
    int first_after = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        if (first_any < 0) first_any = i;
        if (i > last && first_after < 0) first_after = i;
      end
    end
    return (first_after >= 0) ? first_after : first_any;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // the automatic drivers then set inputs for the next edge.
  task automatic step();
    @(posedge clk2);
    #1;
    if (bfm_auto) begin
      tx_done = 1'b0;
      if (tx_start === 1'b1) begin
        bfm_cur_len = $urandom_range(bfm_hi, bfm_lo);
        bfm_cnt     = bfm_cur_len;
        tx_busy     = 1'b1;
      end else if (bfm_cnt > 0) begin
        bfm_cnt--;
        if (bfm_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end
      end
    end
    if (req_auto) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] === 1'b1) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(99) < drop_pct) req_valid[i] = 1'b0;
        if (!req_valid[i] && req_mask[i] && $urandom_range(99) < req_pct) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = DW'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    req_auto  = 1'b0;
    bfm_auto  = 1'b0;
    bfm_cnt   = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_data = '1; tx_busy = 1'b0; tx_done = 1'b1;
    step();
    step();
    checks++; if (req_ready !== '0)    begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== '0)      begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    checks++; if (grant_id !== '0)     begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (frame_done !== '0)   begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0; req_valid = '0; tx_done = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL reset_release_idle: busy=%b req_ready=%b want 0/0", busy, req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    step();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    checks++; if (tx_data !== 8'hA5 || grant_id !== 2'd2) begin errors++; $display("FAIL single_capture: tx_data=%h grant_id=%0d want a5/2", tx_data, grant_id); end
    req_valid = '0;
    req_data  = '0;
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_launch: tx_start=%b tx_data=%h want 1/a5", tx_start, tx_data); end
    // tx_done coinciding with tx_start must be ignored
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (frame_done !== '0 || busy !== 1'b1) begin errors++; $display("FAIL single_early_done: frame_done=%b busy=%b want 0/1", frame_done, busy); end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (frame_done !== 4'b0100) begin errors++; $display("FAIL single_frame_done: got %b want 0100", frame_done); end
    for (int g = 1; g <= GUARD; g++) begin
      step();
      checks++; if (busy !== (g < GUARD) || frame_done !== '0) begin errors++; $display("FAIL single_gap%0d: busy=%b frame_done=%b", g, busy, frame_done); end
    end
  endtask

  task automatic test_two_req();
    int n; int fcyc; bit got;
    do_reset();
    req_mask = 4'b0011; req_pct = 100; drop_pct = 0; req_auto = 1'b1;
    bfm_lo = 20; bfm_hi = 20; bfm_auto = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 50) begin step(); n++; got = (req_ready !== '0); end
    checks++; if (!got || req_ready !== 4'b0001) begin errors++; $display("FAIL two_first_grant: got %b want 0001", req_ready); return; end
    got = 1'b0; n = 0;
    while (!got && n < 100) begin step(); n++; got = (frame_done !== '0); end
    checks++; if (!got || frame_done !== 4'b0001) begin errors++; $display("FAIL two_frame_done0: got %b want 0001", frame_done); return; end
    fcyc = 0;
    got = 1'b0;
    while (!got && fcyc < 50) begin step(); fcyc++; got = (req_ready !== '0); end
    checks++; if (!got || req_ready !== 4'b0010) begin errors++; $display("FAIL two_second_grant: got %b want 0010", req_ready); end
    checks++; if (fcyc != GUARD + 1) begin errors++; $display("FAIL two_gap_spacing: got %0d cycles want %0d", fcyc, GUARD + 1); end
  endtask

  task automatic test_all_rr();
    logic [NREQ-1:0] expv; int n; bit got;
    do_reset();
    req_mask = '1; req_pct = 100; drop_pct = 0; req_auto = 1'b1;
    bfm_lo = 1; bfm_hi = 4; bfm_auto = 1'b1;
    for (int k = 0; k < 2 * NREQ; k++) begin
      got = 1'b0; n = 0;
      while (!got && n < 100) begin step(); n++; got = (req_ready !== '0); end
      expv = '0;
      expv[k % NREQ] = 1'b1;
      checks++;
      if (!got) begin errors++; $display("FAIL rr_wait: no req_ready for grant %0d", k); return; end
      if (req_ready !== expv) begin errors++; $display("FAIL rr_order%0d: got %b want %b", k, req_ready, expv); end
    end
  endtask

  task automatic test_busy_hold();
    do_reset();
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data[0 +: DW] = 8'h3C;
    step();
    req_valid = '0;
    req_data  = '0;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_ready: got %b want 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (tx_start !== 1'b0 || tx_data !== 8'h3C) begin errors++; $display("FAIL hold_wait%0d: tx_start=%b tx_data=%h want 0/3c", k, tx_start, tx_data); end
    end
    tx_busy = 1'b0;
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin errors++; $display("FAIL hold_launch: tx_start=%b tx_data=%h want 1/3c", tx_start, tx_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h77;
    step();
    req_valid = '0;
    step();
    step();
    checks++; if (busy !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL mid_in_frame: busy=%b tx_data=%h want 1/77", busy, tx_data); end
    rst = 1'b1; tx_done = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || frame_done !== '0) begin errors++; $display("FAIL mid_reset: busy=%b tx_start=%b frame_done=%b want 0/0/0", busy, tx_start, frame_done); end
    checks++; if (tx_data !== '0 || grant_id !== '0) begin errors++; $display("FAIL mid_reset_regs: tx_data=%h grant_id=%0d want 0/0", tx_data, grant_id); end
    rst = 1'b0; tx_done = 1'b0; req_valid = '1;
    step();
    checks++; if (req_ready !== 4'b0001 || frame_done !== '0) begin errors++; $display("FAIL mid_priority: req_ready=%b frame_done=%b want 0001/0", req_ready, frame_done); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0]    snap, expv;
    logic [NREQ*DW-1:0] sdata;
    logic [DW-1:0]      exp_byte;
    int w, n, m, model_last;
    bit got, unstable;
    do_reset();
    model_last = NREQ - 1;
    req_mask = '1; req_pct = 30; drop_pct = 4; req_auto = 1'b1;
    bfm_lo = 1; bfm_hi = 6; bfm_auto = 1'b1;
    for (int t = 0; t < 40; t++) begin
      got = 1'b0; n = 0; snap = '0; sdata = '0;
      while (!got && n < 200) begin
        snap  = req_valid;
        sdata = req_data;
        step();
        n++;
        got = (req_ready !== '0);
        checks++;
        if (got != (snap != '0)) begin errors++; $display("FAIL rand_arb_latency: req_ready=%b with sampled valid %b", req_ready, snap); end
      end
      if (!got) begin errors++; $display("FAIL rand_wait_ready: none within 200 cycles at txn %0d", t); return; end
      if (snap == '0) return;
      w          = rr_pick(snap, model_last);
      model_last = w;
      expv       = '0;
      expv[w]    = 1'b1;
      exp_byte   = sdata[w*DW +: DW];
      checks++; if (req_ready !== expv) begin errors++; $display("FAIL rand_grant: got %b want %b (valid %b)", req_ready, expv, snap); end
      checks++; if (tx_data !== exp_byte) begin errors++; $display("FAIL rand_data: got %h want %h", tx_data, exp_byte); end
      checks++; if (grant_id !== IDW'(w)) begin errors++; $display("FAIL rand_grant_id: got %0d want %0d", grant_id, w); end
      step();
      checks++; if (tx_start !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL rand_launch: tx_start=%b req_ready=%b want 1/0", tx_start, req_ready); end
      m = 0; got = 1'b0; unstable = 1'b0;
      while (!got && m < 40) begin
        step();
        m++;
        got = (frame_done !== '0);
        if (tx_data !== exp_byte || tx_start !== 1'b0 || req_ready !== '0) unstable = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL rand_wait_done: no frame_done within 40 cycles"); return; end
      checks++; if (frame_done !== expv || m != bfm_cur_len + 1) begin errors++; $display("FAIL rand_frame_done: got %b after %0d want %b after %0d", frame_done, m, expv, bfm_cur_len + 1); end
      checks++; if (unstable) begin errors++; $display("FAIL rand_hold: tx_data/tx_start/req_ready changed during frame, want %h/0/0", exp_byte); end
      for (int g = 1; g <= GUARD; g++) begin
        step();
        checks++; if (busy !== (g < GUARD) || req_ready !== '0) begin errors++; $display("FAIL rand_gap%0d: busy=%b req_ready=%b", g, busy, req_ready); end
      end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_no_timeout: got %b want 0", timeout_err); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit got; bit fd_seen;
    do_reset();
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 8'h5A;
    step();
    req_valid = '0;
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_launch: got %b want 1", tx_start); end
    fd_seen = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      if (frame_done !== '0) fd_seen = 1'b1;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b want 0", k, timeout_err); end
    end
    step();
    if (frame_done !== '0) fd_seen = 1'b1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", timeout_err); end
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hC3;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      step();
      n++;
      got = (req_ready !== '0);
      if (frame_done !== '0) fd_seen = 1'b1;
    end
    req_valid = '0;
    checks++; if (!got || req_ready !== 4'b0100 || n != GUARD + 1) begin errors++; $display("FAIL to_resume: req_ready=%b after %0d want 0100 after %0d", req_ready, n, GUARD + 1); end
    checks++; if (fd_seen) begin errors++; $display("FAIL to_no_frame_done: got pulse want none"); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    do_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    test_reset();
    test_single();
    test_two_req();
    test_all_rr();
    test_busy_hold();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NREQ requesters using round-robin arbitration.
- Captures one byte from the winning requester and launches it with a single-cycle start pulse.
- Holds the grant until the transmitter reports frame completion, then inserts a guard gap before re-arbitrating.
- Sits between on-chip byte producers and the UART TX serializer, which uses the same clk2 domain as the receiver.

Parameters:
- NREQ, 4: number of requesters; NREQ >= 2.
- DW, 8: data byte width.
- GUARD, 2: idle cycles between end of one frame and next arbitration; 0 is allowed.
- TIMEOUT, 4096: clk2 cycles allowed from tx_start to tx_done. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk2, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous active-high reset.
- req_valid, input, NREQ: per-requester byte-pending flag. Must be held until matching req_ready.
- req_data, input, NREQ*DW: flattened bytes; requester i occupies bits [i*DW +: DW].
- req_ready, output, NREQ: one-cycle pulse; byte of requester i captured.
- tx_start, output, 1: one-cycle pulse to the transmitter.
- tx_data, output, DW: byte to transmit; stable from the cycle of tx_start until tx_done.
- tx_busy, input, 1: transmitter is shifting a frame.
- tx_done, input, 1: one-cycle pulse at end of the stop bit.
- grant_id, output, $clog2(NREQ): current/last granted requester.
- frame_done, output, NREQ: one-cycle pulse to the requester whose frame completed.
- busy, output, 1: high in any state other than IDLE.
- timeout_err, output, 1: sticky error flag; meaningful only with the macro, otherwise tied 0.

Behaviour:
- Reset values:
  - state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, frame_done=0, busy=0, timeout_err=0.
- Reset asserted mid-frame: everything returns to the reset values on the next edge. No frame_done is issued. The transmitter is reset by the same rst.
- States:
  - IDLE: if any req_valid, pick the winner by scanning from (last_grant+1) mod NREQ upward with wrap. On the same edge:
    - grant_id<=winner; last_grant<=winner.
    - tx_data<=req_data[winner]; req_ready[winner]<=1 for one cycle.
    - go to LAUNCH.
    - If no req_valid, stay in IDLE.
  - LAUNCH: if tx_busy=0, tx_start<=1 for one cycle and go to WAIT_DONE. If tx_busy=1, wait here with tx_start=0.
  - WAIT_DONE: on tx_done=1, frame_done[grant_id]<=1 for one cycle and go to GAP. A tx_done in the same cycle tx_start is high is ignored.
  - GAP: count GUARD cycles, then go to IDLE. If GUARD=0, go straight to IDLE.
- Latency: req_valid sampled in IDLE at edge N gives req_ready high in cycle N+1 and tx_start high in cycle N+2, provided tx_busy=0.
- tx_done or tx_busy activity outside LAUNCH/WAIT_DONE is ignored.
- req_valid changes after the IDLE sampling edge have no effect on the in-flight frame. A requester that drops valid before being granted is skipped.
- Only one req_ready bit and at most one frame_done bit are high in any cycle.
- req_ready and frame_done never coincide for the same frame.
- Round-robin wraps: after grant NREQ-1, the scan starts at 0. A sole active requester is re-granted each round.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on tx_start and increments in WAIT_DONE.
  - Reaching TIMEOUT without tx_done sets timeout_err=1 (sticky until rst).
  - The frame is abandoned with no frame_done pulse, and the block goes to GAP.
- When undefined: no counter; WAIT_DONE waits indefinitely; timeout_err is constant 0.

Test Plan:
- Only req_valid[2]=1 with data 0xA5 → req_ready[2] one cycle later, then tx_start with tx_data=0xA5, grant_id=2. A tx_done pulse gives frame_done[2], then GUARD=2 idle cycles.
- req_valid=4'b0011 held, transmitter model 20 cycles/frame → grants in order 0, 1. frame_done[0] precedes req_ready[1] by exactly GUARD+1 cycles.
- All four valid continuously → grant sequence 0,1,2,3,0,1; no requester is granted twice within any four consecutive grants.
- tx_busy held high 5 cycles after capture → tx_start delayed until the first cycle tx_busy=0; tx_data stays unchanged throughout.
- rst asserted during WAIT_DONE → next cycle busy=0, tx_start=0, no frame_done. After release, requester 0 has priority again.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=16, tx_done never asserted → timeout_err=1 exactly 16 cycles after tx_start, no frame_done, arbitration resumes.
